multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
Moore-style control FSM that sequences a shared-memory, multi-cycle MIPS datapath: one ALU, one unified instruction/data memory, PC and IR registers. It replaces the single-cycle opcode decode with a per-instruction state walk (fetch, decode, execute, memory, writeback). It stalls on a memory ready handshake and counts retired instructions. ALU_Op encoding is shared with the existing ALU control: 000 add, 001 sub, 010 R-type funct, 011 and, 100 or, 101 slt, 110 xor, 111 lui.

Parameters:
CNT_W, 32, width of the retired-instruction counter
WAIT_LIMIT, 255, maximum cycles spent waiting for Mem_Ready in one memory state before abort

Ports:
Clk  input  1  clock, rising edge
Rst_N  input  1  asynchronous active-low reset
Opcode  input  6  IR[31:26], stable from DECODE until return to FETCH
Zero  input  1  ALU zero flag
Mem_Ready  input  1  memory completes the current read/write this cycle
Halt  input  1  hold in FETCH without issuing a read
PC_Write  output  1  PC load enable
PC_Src  output  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target
IorD  output  1  memory address select: 0 PC, 1 ALUOut
Mem_Read  output  1  memory read strobe
Mem_Write  output  1  memory write strobe
IR_Write  output  1  IR load enable
Reg_Dst  output  2  00 rt, 01 rd, 10 $31
Mem_to_Reg  output  2  00 ALUOut, 01 MDR, 10 PC
Reg_Write  output  1  register file write enable
ALU_Src_A  output  1  0 PC, 1 register A
ALU_Src_B  output  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 imm shifted left 2
ALU_Op  output  3  ALU operation, encoding above
State  output  4  current state code, for debug
Illegal_Op  output  1  sticky: an unsupported opcode was decoded
Mem_Timeout  output  1  sticky: a memory wait exceeded WAIT_LIMIT
Instr_Retired  output  CNT_W  count of completed instructions

Behaviour:
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, I_EXEC 7, ALU_WB 8, BRANCH 9, JUMP 10, JAL 11.
- Reset (async, Rst_N low): state goes to FETCH immediately; Instr_Retired, Illegal_Op, Mem_Timeout and the wait counter go to 0. While Rst_N is low, every strobe output is held at 0 (PC_Write, Mem_Read, Mem_Write, IR_Write, Reg_Write). All mux selects are 0.
- Control outputs are combinational from State, plus Opcode, Zero and Mem_Ready where noted. Every unlisted output is 0.
- FETCH: if Halt, all outputs are 0 and the FSM stays in FETCH. Otherwise Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=000, PC_Src=00. IR_Write and PC_Write equal Mem_Ready. When Mem_Ready=1, go to DECODE.
- DECODE: ALU_Src_A=0, ALU_Src_B=11, ALU_Op=000 (computes the branch target). Next state by Opcode:
  - 35 or 43 -> MEM_ADDR
  - 0 -> R_EXEC
  - 8, 12, 13, 10, 14 or 15 -> I_EXEC
  - 4 or 5 -> BRANCH
  - 2 -> JUMP
  - 3 -> JAL
  - any other opcode -> FETCH; set Illegal_Op; do not increment the counter.
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=000. Next is MEM_READ (op 35) or MEM_WRITE (op 43).
- MEM_READ: Mem_Read=1, IorD=1. On Mem_Ready go to MEM_WB.
- MEM_WB: Reg_Dst=00, Mem_to_Reg=01, Reg_Write=1. Go to FETCH and retire.
- MEM_WRITE: Mem_Write=1, IorD=1. On Mem_Ready go to FETCH and retire.
- R_EXEC: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=010. Go to ALU_WB.
- I_EXEC: ALU_Src_A=1, ALU_Src_B=10. ALU_Op by opcode: 8->000, 12->011, 13->100, 10->101, 14->110, 15->111. Go to ALU_WB.
- ALU_WB: Reg_Dst=01 if Opcode=0, else 00. Mem_to_Reg=00, Reg_Write=1. Go to FETCH and retire.
- BRANCH: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=001, PC_Src=01. PC_Write=(Opcode=4 and Zero) or (Opcode=5 and not Zero). Go to FETCH and retire.
- JUMP: PC_Src=10, PC_Write=1. Go to FETCH and retire.
- JAL: PC_Src=10, PC_Write=1, Reg_Dst=10, Mem_to_Reg=10, Reg_Write=1. The register write uses the pre-update PC (PC+4). Go to FETCH and retire.
- Latency with zero wait states, counted as cycles in FETCH through the last state:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq, bne, j, jal: 3
- Each memory wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE, and whenever Mem_Ready=1.
  - Increments each cycle spent in one of those three states with Mem_Ready=0 (not counted in FETCH while Halt=1).
  - When it reaches WAIT_LIMIT with Mem_Ready still 0: set Mem_Timeout and go to FETCH. Strobes deassert on the next cycle, nothing is retired, and Instr_Retired is unchanged.
- Retire: Instr_Retired increments by 1 on the clock edge leaving the final state of an instruction. It wraps modulo 2^CNT_W.
- Halt is sampled only in FETCH. If Halt=1 and Mem_Ready=1 together, Halt wins: no read and no state change.

Test Plan:
- Reset then R-type (Opcode=0), Mem_Ready tied 1 -> states 0,1,6,8,0. Reg_Write=1 with Reg_Dst=01 only in state 8. Instr_Retired=1.
- lw (35) with Mem_Ready low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0 (7 cycles). Mem_to_Reg=01 in state 4. Counter +1.
- beq (4) with Zero=1 -> PC_Write=1, PC_Src=01 in BRANCH. bne (5) with Zero=1 -> PC_Write=0 in BRANCH. Both retire.
- jal (3) -> states 0,1,11. In state 11: PC_Write=1, Reg_Dst=10, Mem_to_Reg=10, Reg_Write=1.
- Opcode=63 -> returns to FETCH after DECODE, Illegal_Op=1 sticky, Instr_Retired unchanged. WAIT_LIMIT=4 with Mem_Ready held 0 in MEM_WRITE -> Mem_Timeout=1, back to FETCH, no retire.
- Assert Rst_N low in MEM_READ mid-wait -> State=0 and all strobes 0 within the same cycle, counters 0. After release, fetch resumes; Halt=1 in FETCH keeps Mem_Read=0 indefinitely.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: walks each instruction through fetch, decode,
// execute, memory and writeback states over a shared ALU and unified memory.
// Stalls on the memory ready handshake, aborts long waits, counts retirements.
module multi_cycle_control #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_retired
);

  localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpJal   = 6'd3;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBne   = 6'd5;
  localparam logic [5:0] OpAddi  = 6'd8;
  localparam logic [5:0] OpSlti  = 6'd10;
  localparam logic [5:0] OpAndi  = 6'd12;
  localparam logic [5:0] OpOri   = 6'd13;
  localparam logic [5:0] OpXori  = 6'd14;
  localparam logic [5:0] OpLui   = 6'd15;
  localparam logic [5:0] OpLw    = 6'd35;
  localparam logic [5:0] OpSw    = 6'd43;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StIExec    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJump     = 4'd10,
    StJal      = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q, timeout_q;
  logic             retire, set_illegal, set_timeout;
  logic             wait_last;

  assign wait_last = (wait_q == WaitLast);

  // Next state, wait counter and event flags.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (halt) begin
          wait_d = wait_q;
        end else if (mem_ready) begin
          state_d = StDecode;
        end else if (wait_last) begin
          set_timeout = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        case (opcode)
          OpLw, OpSw:                                       state_d = StMemAddr;
          OpRtype:                                          state_d = StRExec;
          OpAddi, OpAndi, OpOri, OpSlti, OpXori, OpLui:    state_d = StIExec;
          OpBeq, OpBne:                                     state_d = StBranch;
          OpJ:                                              state_d = StJump;
          OpJal:                                            state_d = StJal;
          default: begin
            state_d     = StFetch;
            set_illegal = 1'b1;
          end
        endcase
      end
      StMemAddr: state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      StMemRead: begin
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (wait_last) begin
          state_d     = StFetch;
          set_timeout = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StMemWrite: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (wait_last) begin
          state_d     = StFetch;
          set_timeout = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StRExec, StIExec: state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJump, StJal: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // State, wait counter, sticky flags and retirement counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Moore control decode; everything forced low while reset is asserted.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          if (!halt) begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
          end
        end
        StDecode:  alu_src_b = 2'b11;
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StMemRead: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        StMemWb: begin
          mem_to_reg = 2'b01;
          reg_write  = 1'b1;
        end
        StMemWrite: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        StRExec: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b010;
        end
        StIExec: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (opcode)
            OpAndi:  alu_op = 3'b011;
            OpOri:   alu_op = 3'b100;
            OpSlti:  alu_op = 3'b101;
            OpXori:  alu_op = 3'b110;
            OpLui:   alu_op = 3'b111;
            default: alu_op = 3'b000;
          endcase
        end
        StAluWb: begin
          reg_dst   = (opcode == OpRtype) ? 2'b01 : 2'b00;
          reg_write = 1'b1;
        end
        StBranch: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b001;
          pc_src    = 2'b01;
          pc_write  = ((opcode == OpBeq) && zero) || ((opcode == OpBne) && !zero);
        end
        StJump: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        StJal: begin
          // Register write captures PC+4 before the PC takes the jump target.
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          reg_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state         = state_q;
  assign illegal_op    = illegal_q;
  assign mem_timeout   = timeout_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control with hand-computed state walks.
module tb_multi_cycle_control;

  logic        clk, rst_n;
  logic [5:0]  opcode;
  logic        zero, mem_ready, halt;
  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic        illegal_op, mem_timeout;
  logic [31:0] instr_retired;

  int n_checks = 0;
  int n_fail   = 0;

  multi_cycle_control #(.CNT_W(32), .WAIT_LIMIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .halt          (halt),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .state         (state),
    .illegal_op    (illegal_op),
    .mem_timeout   (mem_timeout),
    .instr_retired (instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; mem_ready = 1'b1; opcode = 6'd0; zero = 1'b0;
    #3;
    check("rst state", 32'(state), 0);
    check("rst mem_read", 32'(mem_read), 0);
    check("rst pc_write", 32'(pc_write), 0);
    check("rst retired", instr_retired, 0);
    tick();
    rst_n = 1'b1;
    #1;

    // R-type: 0,1,6,8,0
    check("r fetch state", 32'(state), 0);
    check("r fetch mem_read", 32'(mem_read), 1);
    check("r fetch ir_write", 32'(ir_write), 1);
    check("r fetch alu_src_b", 32'(alu_src_b), 1);
    tick(); check("r decode state", 32'(state), 1);
    check("r decode alu_src_b", 32'(alu_src_b), 3);
    tick(); check("r exec state", 32'(state), 6);
    check("r exec alu_op", 32'(alu_op), 2);
    check("r exec reg_write", 32'(reg_write), 0);
    tick(); check("r wb state", 32'(state), 8);
    check("r wb reg_write", 32'(reg_write), 1);
    check("r wb reg_dst", 32'(reg_dst), 1);
    tick(); check("r done state", 32'(state), 0);
    check("r retired", instr_retired, 1);

    // lw with two wait cycles: 0,1,2,3,3,3,4,0
    opcode = 6'd35;
    tick(); check("lw decode", 32'(state), 1);
    tick(); check("lw addr", 32'(state), 2);
    check("lw addr alu_src_b", 32'(alu_src_b), 2);
    mem_ready = 1'b0;
    tick(); check("lw read", 32'(state), 3);
    check("lw read iord", 32'(iord), 1);
    check("lw read mem_read", 32'(mem_read), 1);
    tick(); check("lw wait1", 32'(state), 3);
    tick(); check("lw wait2", 32'(state), 3);
    mem_ready = 1'b1;
    tick(); check("lw wb", 32'(state), 4);
    check("lw wb mem_to_reg", 32'(mem_to_reg), 1);
    check("lw wb reg_write", 32'(reg_write), 1);
    tick(); check("lw done", 32'(state), 0);
    check("lw retired", instr_retired, 2);

    // beq taken, bne not taken with zero=1
    opcode = 6'd4; zero = 1'b1;
    tick(); tick(); check("beq state", 32'(state), 9);
    check("beq pc_write", 32'(pc_write), 1);
    check("beq pc_src", 32'(pc_src), 1);
    check("beq alu_op", 32'(alu_op), 1);
    tick(); check("beq retired", instr_retired, 3);
    opcode = 6'd5;
    tick(); tick(); check("bne state", 32'(state), 9);
    check("bne pc_write", 32'(pc_write), 0);
    tick(); check("bne retired", instr_retired, 4);
    zero = 1'b0;

    // jal: 0,1,11
    opcode = 6'd3;
    tick(); tick(); check("jal state", 32'(state), 11);
    check("jal pc_write", 32'(pc_write), 1);
    check("jal pc_src", 32'(pc_src), 2);
    check("jal reg_dst", 32'(reg_dst), 2);
    check("jal mem_to_reg", 32'(mem_to_reg), 2);
    check("jal reg_write", 32'(reg_write), 1);
    tick(); check("jal done", 32'(state), 0);
    check("jal retired", instr_retired, 5);

    // ori: I-type path
    opcode = 6'd13;
    tick(); tick(); check("ori state", 32'(state), 7);
    check("ori alu_op", 32'(alu_op), 4);
    tick(); check("ori wb reg_dst", 32'(reg_dst), 0);
    tick(); check("ori retired", instr_retired, 6);

    // illegal opcode
    opcode = 6'd63;
    tick(); tick(); check("ill state", 32'(state), 0);
    check("ill flag", 32'(illegal_op), 1);
    check("ill retired", instr_retired, 6);

    // sw, zero wait states: 0,1,2,5,0
    opcode = 6'd43;
    tick(); tick(); tick(); check("sw state", 32'(state), 5);
    check("sw mem_write", 32'(mem_write), 1);
    tick(); check("sw retired", instr_retired, 7);

    // sw timeout with WAIT_LIMIT=4
    tick(); tick(); check("swt addr", 32'(state), 2);
    mem_ready = 1'b0;
    tick(); check("swt write", 32'(state), 5);
    tick(); tick(); tick();
    check("swt still waiting", 32'(state), 5);
    check("swt no timeout yet", 32'(mem_timeout), 0);
    tick(); check("swt abort state", 32'(state), 0);
    check("swt timeout flag", 32'(mem_timeout), 1);
    check("swt retired", instr_retired, 7);
    check("ill still sticky", 32'(illegal_op), 1);
    mem_ready = 1'b1;

    // async reset mid-wait in MEM_READ
    opcode = 6'd35;
    tick(); tick(); mem_ready = 1'b0;
    tick(); tick(); check("rmid in read", 32'(state), 3);
    rst_n = 1'b0;
    #1;
    check("rmid state", 32'(state), 0);
    check("rmid mem_read", 32'(mem_read), 0);
    check("rmid iord", 32'(iord), 0);
    check("rmid retired", instr_retired, 0);
    check("rmid illegal", 32'(illegal_op), 0);
    check("rmid timeout", 32'(mem_timeout), 0);

    // halt holds FETCH with no read even when memory is ready
    tick();
    halt = 1'b1; mem_ready = 1'b1; rst_n = 1'b1;
    #1;
    check("halt mem_read", 32'(mem_read), 0);
    check("halt ir_write", 32'(ir_write), 0);
    tick(); tick(); tick();
    check("halt state", 32'(state), 0);
    check("halt mem_read later", 32'(mem_read), 0);
    halt = 1'b0;
    #1;
    check("unhalt mem_read", 32'(mem_read), 1);
    tick(); check("unhalt decode", 32'(state), 1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
